gemm_tile_sequencer: RTL

Parametrised tile-loop sequencer for the GEMM accelerator. It replaces the fixed 4x4x4 single-pass control with a generic M×K×N tile engine that supports arbitrary runtime matrix sizes, including sizes that are not multiples of the tile dimensions. It issues SRAM A/B read addresses in tile-packed order, produces MAC-array control (valid, clear, edge masks) aligned to a configurable SRAM read latency, and issues one SRAM C write per output tile. It sits inside `gemm_accelerator_top`, between the start/size inputs and the MAC array and SRAMs.

---
 rtl/gemm_tile_sequencer_pkg.sv | 28 ++
 rtl/gemm_tile_sequencer_if.sv | 35 +++
 rtl/gemm_tile_sequencer_issue_pipe.sv | 30 +++
 rtl/gemm_tile_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared types for the GEMM tile sequencer: FSM states, issue-pipe tag and helpers.
// Tag fields are sized to fixed upper bounds so one struct serves every parameterisation.
package gemm_pkg;

    localparam int unsigned TagAddrW = 16;  // upper bound on AddrWidth
    localparam int unsigned TagMaskW = 16;  // upper bound on M and N

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic                valid;
        logic                clear;
        logic                last_k;
        logic [TagAddrW-1:0] c_addr;
        logic [TagMaskW-1:0] row_mask;
        logic [TagMaskW-1:0] col_mask;
    } issue_tag_t;

    function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/gemm_tile_sequencer_if.sv
// Start/size request and SRAM/MAC control bundle of the tile sequencer.
// master = sequencer side, slave = accelerator datapath / environment side.
interface gemm_tile_sequencer_if #(
    parameter int unsigned M             = 4,
    parameter int unsigned N             = 4,
    parameter int unsigned AddrWidth     = 10,
    parameter int unsigned SizeAddrWidth = 8
);
    logic                     start_i;
    logic [SizeAddrWidth-1:0] M_size_i;
    logic [SizeAddrWidth-1:0] K_size_i;
    logic [SizeAddrWidth-1:0] N_size_i;
    logic [AddrWidth-1:0]     sram_a_addr_o;
    logic [AddrWidth-1:0]     sram_b_addr_o;
    logic [AddrWidth-1:0]     sram_c_addr_o;
    logic                     sram_c_we_o;
    logic                     mac_valid_o;
    logic                     mac_clear_o;
    logic [M-1:0]             row_mask_o;
    logic [N-1:0]             col_mask_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        input  start_i, M_size_i, K_size_i, N_size_i,
        output sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
               mac_valid_o, mac_clear_o, row_mask_o, col_mask_o, busy_o, done_o
    );

    modport slave (
        output start_i, M_size_i, K_size_i, N_size_i,
        input  sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
               mac_valid_o, mac_clear_o, row_mask_o, col_mask_o, busy_o, done_o
    );
endinterface

// File: rtl/gemm_tile_sequencer_issue_pipe.sv
// Delay line aligning issued k-step tags with SRAM read data (ReadLatency stages).
module gemm_issue_pipe
    import gemm_pkg::*;
#(
    parameter int unsigned ReadLatency = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  issue_tag_t i_tag,
    output issue_tag_t o_tag,
    output logic       o_busy
);
    issue_tag_t r_stage [ReadLatency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < ReadLatency; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int unsigned i = 1; i < ReadLatency; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_tag = r_stage[ReadLatency-1];

    always_comb begin
        o_busy = 1'b0;
        for (int unsigned i = 0; i < ReadLatency; i++) o_busy = o_busy | r_stage[i].valid;
    end
endmodule

// File: rtl/gemm_tile_sequencer.sv
// Output-stationary M x K x N tile-loop sequencer: issues A/B reads, MAC control
// aligned to the SRAM read latency, and one C write per output tile.
module gemm_tile_sequencer
    import gemm_pkg::*;
#(
    parameter int unsigned M             = 4,
    parameter int unsigned N             = 4,
    parameter int unsigned K             = 4,
    parameter int unsigned AddrWidth     = 10,
    parameter int unsigned SizeAddrWidth = 8,
    parameter int unsigned ReadLatency   = 1
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    gemm_tile_sequencer_if.master bus
);
    localparam int unsigned   CW  = AddrWidth + 1;
    localparam logic [CW-1:0] One = CW'(1);

    seq_state_e               r_state, w_state_nxt;
    logic [SizeAddrWidth-1:0] r_msize, r_nsize;
    logic [CW-1:0]            r_mt_cnt, r_kt_cnt, r_nt_cnt;
    logic [CW-1:0]            r_mt, r_nt, r_kt;
    logic [AddrWidth-1:0]     r_a_addr, r_b_addr, r_c_addr;
    logic                     r_c_we;
    issue_tag_t               r_tag, w_tag_nxt, w_pipe_out;

    logic                     w_pipe_busy, w_issue, w_accept, w_zero_size, w_last_step;
    logic [CW-1:0]            w_mt_cnt, w_kt_cnt, w_nt_cnt, w_mt, w_nt, w_kt;
    logic [SizeAddrWidth-1:0] w_msize, w_nsize;
    logic [AddrWidth-1:0]     w_a_addr, w_b_addr, w_c_addr;
    logic [M-1:0]             w_row_mask;
    logic [N-1:0]             w_col_mask;

    // In IDLE the step-0 tag is built straight from the inputs being latched.
    assign w_mt_cnt = (r_state == IDLE) ? CW'(ceil_div(32'(bus.M_size_i), M)) : r_mt_cnt;
    assign w_kt_cnt = (r_state == IDLE) ? CW'(ceil_div(32'(bus.K_size_i), K)) : r_kt_cnt;
    assign w_nt_cnt = (r_state == IDLE) ? CW'(ceil_div(32'(bus.N_size_i), N)) : r_nt_cnt;
    assign w_msize  = (r_state == IDLE) ? bus.M_size_i : r_msize;
    assign w_nsize  = (r_state == IDLE) ? bus.N_size_i : r_nsize;

    assign w_zero_size = (bus.M_size_i == '0) || (bus.K_size_i == '0) || (bus.N_size_i == '0);
    assign w_last_step = (r_mt == r_mt_cnt - One) && (r_nt == r_nt_cnt - One)
                      && (r_kt == r_kt_cnt - One);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_accept    = 1'b0;
        w_mt        = r_mt;
        w_nt        = r_nt;
        w_kt        = r_kt;
        case (r_state)
            IDLE: begin
                if (bus.start_i) begin
                    w_accept = 1'b1;
                    w_mt     = '0;
                    w_nt     = '0;
                    w_kt     = '0;
                    if (w_zero_size) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                        w_issue     = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_last_step) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_issue = 1'b1;
                    if (r_kt == r_kt_cnt - One) begin
                        w_kt = '0;
                        if (r_nt == r_nt_cnt - One) begin
                            w_nt = '0;
                            w_mt = r_mt + One;
                        end else begin
                            w_nt = r_nt + One;
                        end
                    end else begin
                        w_kt = r_kt + One;
                    end
                end
            end
            DRAIN:   if (!w_pipe_busy) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_a_addr = AddrWidth'(w_mt * w_kt_cnt + w_kt);
    assign w_b_addr = AddrWidth'(w_kt * w_nt_cnt + w_nt);
    assign w_c_addr = AddrWidth'(w_mt * w_nt_cnt + w_nt);

    always_comb begin
        w_row_mask = '0;
        w_col_mask = '0;
        for (int unsigned r = 0; r < M; r++)
            w_row_mask[r] = (32'(w_mt) * M + r) < 32'(w_msize);
        for (int unsigned c = 0; c < N; c++)
            w_col_mask[c] = (32'(w_nt) * N + c) < 32'(w_nsize);
    end

    always_comb begin
        w_tag_nxt          = '0;
        w_tag_nxt.valid    = 1'b1;
        w_tag_nxt.clear    = (w_kt == '0);
        w_tag_nxt.last_k   = (w_kt == w_kt_cnt - One);
        w_tag_nxt.c_addr   = TagAddrW'(w_c_addr);
        w_tag_nxt.row_mask = TagMaskW'(w_row_mask);
        w_tag_nxt.col_mask = TagMaskW'(w_col_mask);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_msize  <= '0;
            r_nsize  <= '0;
            r_mt_cnt <= '0;
            r_kt_cnt <= '0;
            r_nt_cnt <= '0;
            r_mt     <= '0;
            r_nt     <= '0;
            r_kt     <= '0;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_c_addr <= '0;
            r_c_we   <= 1'b0;
            r_tag    <= '0;
        end else begin
            if (w_accept) begin
                r_msize  <= bus.M_size_i;
                r_nsize  <= bus.N_size_i;
                r_mt_cnt <= w_mt_cnt;
                r_kt_cnt <= w_kt_cnt;
                r_nt_cnt <= w_nt_cnt;
            end
            if (w_issue) begin
                r_mt     <= w_mt;
                r_nt     <= w_nt;
                r_kt     <= w_kt;
                r_a_addr <= w_a_addr;
                r_b_addr <= w_b_addr;
            end
            r_tag  <= w_issue ? w_tag_nxt : '0;
            // Accumulator register stage: write lands one cycle after the last k-step.
            r_c_we <= w_pipe_out.valid & w_pipe_out.last_k;
            if (w_pipe_out.valid & w_pipe_out.last_k)
                r_c_addr <= AddrWidth'(w_pipe_out.c_addr);
        end
    end

    gemm_issue_pipe #(
        .ReadLatency(ReadLatency)
    ) u_issue_pipe (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .i_tag (r_tag),
        .o_tag (w_pipe_out),
        .o_busy(w_pipe_busy)
    );

    assign bus.sram_a_addr_o = r_a_addr;
    assign bus.sram_b_addr_o = r_b_addr;
    assign bus.sram_c_addr_o = r_c_addr;
    assign bus.sram_c_we_o   = r_c_we;
    assign bus.mac_valid_o   = w_pipe_out.valid;
    assign bus.mac_clear_o   = w_pipe_out.clear;
    assign bus.row_mask_o    = M'(w_pipe_out.row_mask);
    assign bus.col_mask_o    = N'(w_pipe_out.col_mask);
    assign bus.busy_o        = (r_state != IDLE);
    assign bus.done_o        = (r_state == DONE);
endmodule
